// File: rtl/tpu_pkg.sv
// Shared defaults for the accumulator/writeback path.
// Holds the default lane and array geometry used by accumulator_writeback
// and the writeback FSM state encoding.
package tpu_pkg;

  localparam int DEF_PARTIAL_SUM_BW = 20;
  localparam int DEF_MATRIX_SIZE    = 8;
  localparam int DEF_DATA_BW        = 8;
  localparam int DEF_ACC_BW         = 24;
  localparam int DEF_ACC_DEPTH      = 8;
  localparam int DEF_ADDRESSSIZE    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/acc_lane_quant.sv
// Per-lane output quantiser: optional ReLU, arithmetic right shift, then
// saturation to a signed DATA_BW value.
// Ports:
//   acc      - signed accumulator lane value
//   relu_en  - clamp negative values to zero before shifting
//   shift    - arithmetic right shift amount
//   q        - saturated signed DATA_BW result
module acc_lane_quant #(
  parameter int ACC_BW  = 24,
  parameter int DATA_BW = 8
) (
  input  logic signed [ACC_BW-1:0]  acc,
  input  logic                      relu_en,
  input  logic        [3:0]         shift,
  output logic        [DATA_BW-1:0] q
);

  localparam logic signed [ACC_BW-1:0] Q_MAX = ACC_BW'((2 ** (DATA_BW - 1)) - 1);
  localparam logic signed [ACC_BW-1:0] Q_MIN = ~Q_MAX;

  logic signed [ACC_BW-1:0] relu_v;
  logic signed [ACC_BW-1:0] shifted;

  assign relu_v  = (relu_en && acc[ACC_BW-1]) ? '0 : acc;
  assign shifted = relu_v >>> shift;

  always_comb begin
    if (shifted > Q_MAX) begin
      q = {1'b0, {(DATA_BW-1){1'b1}}};
    end else if (shifted < Q_MIN) begin
      q = {1'b1, {(DATA_BW-1){1'b0}}};
    end else begin
      q = shifted[DATA_BW-1:0];
    end
  end

endmodule

// File: rtl/accumulator_writeback.sv
// Row accumulator with quantised writeback to the Unified Buffer.
// Result rows are accumulated (or overwritten) into a small row buffer while
// idle; a flush drains every used row through the lane quantisers to the UB,
// one row per accepted write, then clears the buffer.
// Ports:
//   clk, rstn              - clock, async active-low reset
//   in_valid, in_data      - de-skewed signed result row, lane 0 at LSBs
//   acc_mode               - 0 overwrite row, 1 add into row (saturating)
//   flush                  - start writeback (sampled in IDLE only)
//   wb_base_addr           - UB address of row 0, captured on flush
//   relu_en, out_shift     - quantiser config, captured on flush
//   ub_we, ub_addr, ub_data, ub_ready - UB write handshake
//   busy, done             - status; done is a one-cycle pulse
//   sat_err, drop_err      - sticky accumulate-saturation / dropped-row flags
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | accepting rows into the accumulator, waiting for flush
// ST_DRAIN | presenting rows 0..rows_used-1 to the UB
// ST_DONE  | one-cycle completion pulse; buffer already cleared
module accumulator_writeback
  import tpu_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int DATA_BW        = DEF_DATA_BW,
  parameter int ACC_BW         = DEF_ACC_BW,
  parameter int ACC_DEPTH      = DEF_ACC_DEPTH,
  parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  input  logic                              acc_mode,
  input  logic                              flush,
  input  logic [ADDRESSSIZE-1:0]            wb_base_addr,
  input  logic                              relu_en,
  input  logic [3:0]                        out_shift,
  output logic                              ub_we,
  output logic [ADDRESSSIZE-1:0]            ub_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]    ub_data,
  input  logic                              ub_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              sat_err,
  output logic                              drop_err
);

  localparam int PTR_W = $clog2(ACC_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_state_e                        state;
  logic [PTR_W-1:0]                 wr_ptr;
  logic [PTR_W-1:0]                 rd_ptr;
  logic [CNT_W-1:0]                 rows_used;
  logic [ACC_BW-1:0]                acc_mem [ACC_DEPTH][MATRIX_SIZE];
  logic [MATRIX_SIZE-1:0][ACC_BW-1:0] row_next;
  logic [MATRIX_SIZE-1:0]           lane_sat;
  logic [ADDRESSSIZE-1:0]           base_q;
  logic                             relu_q;
  logic [3:0]                       shift_q;
  logic [DATA_BW*MATRIX_SIZE-1:0]   quant_row;
  logic                             last_row;
  logic                             wr_accept;

  for (genvar l = 0; l < MATRIX_SIZE; l++) begin : g_lane
    logic [PARTIAL_SUM_BW-1:0] in_lane;
    logic [ACC_BW-1:0]         in_ext;
    logic [ACC_BW:0]           sum;

    assign in_lane = in_data[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    assign in_ext  = {{(ACC_BW-PARTIAL_SUM_BW){in_lane[PARTIAL_SUM_BW-1]}}, in_lane};
    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign sum     = {acc_mem[wr_ptr][l][ACC_BW-1], acc_mem[wr_ptr][l]}
                   + {in_ext[ACC_BW-1], in_ext};
    assign lane_sat[l] = acc_mode && (sum[ACC_BW] != sum[ACC_BW-1]);
    assign row_next[l] = !acc_mode   ? in_ext :
                         lane_sat[l] ? (sum[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}}
                                                    : {1'b0, {(ACC_BW-1){1'b1}}}) :
                                       sum[ACC_BW-1:0];

    acc_lane_quant #(
      .ACC_BW  (ACC_BW),
      .DATA_BW (DATA_BW)
    ) u_quant (
      .acc     (acc_mem[rd_ptr][l]),
      .relu_en (relu_q),
      .shift   (shift_q),
      .q       (quant_row[l*DATA_BW +: DATA_BW])
    );
  end

  assign last_row  = ({1'b0, rd_ptr} == (rows_used - CNT_W'(1)));
  assign wr_accept = ub_we && ub_ready;

  // Address and data come straight from registered state, so they cannot
  // move while a write is stalled; zeroed whenever no write is presented.
  assign ub_addr = ub_we ? (base_q + ADDRESSSIZE'(rd_ptr)) : '0;
  assign ub_data = ub_we ? quant_row : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rows_used <= '0;
      ub_we     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_err   <= 1'b0;
      drop_err  <= 1'b0;
      base_q    <= '0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      for (int r = 0; r < ACC_DEPTH; r++) begin
        for (int l = 0; l < MATRIX_SIZE; l++) begin
          acc_mem[r][l] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int l = 0; l < MATRIX_SIZE; l++) begin
              acc_mem[wr_ptr][l] <= row_next[l];
            end
            if (|lane_sat) sat_err <= 1'b1;
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (rows_used != CNT_W'(ACC_DEPTH)) rows_used <= rows_used + CNT_W'(1);
          end
          if (flush) begin
            base_q  <= wb_base_addr;
            relu_q  <= relu_en;
            shift_q <= out_shift;
            busy    <= 1'b1;
            // A row arriving with the flush is part of this drain.
            if (in_valid || (rows_used != '0)) begin
              state <= ST_DRAIN;
              ub_we <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (in_valid) drop_err <= 1'b1;
          if (wr_accept) begin
            if (last_row) begin
              state     <= ST_DONE;
              ub_we     <= 1'b0;
              done      <= 1'b1;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              rows_used <= '0;
              for (int r = 0; r < ACC_DEPTH; r++) begin
                for (int l = 0; l < MATRIX_SIZE; l++) begin
                  acc_mem[r][l] <= '0;
                end
              end
            end else begin
              rd_ptr <= rd_ptr + PTR_W'(1);
            end
          end
        end

        ST_DONE: begin
          if (in_valid) drop_err <= 1'b1;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          ub_we <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_writeback.sv
// Self-checking bench for accumulator_writeback: expected UB writes are
// produced by a behavioural model when rows/flushes are driven and compared
// by a write monitor as the DUT presents accepted writes.
module tb_accumulator_writeback;

  localparam int PS = 20;
  localparam int MS = 8;
  localparam int DB = 8;
  localparam int AB = 24;
  localparam int AD = 8;
  localparam int AW = 10;
  localparam int ACC_MAX = (1 << (AB - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AB - 1));

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic [PS*MS-1:0] in_data;
  logic             acc_mode;
  logic             flush;
  logic [AW-1:0]    wb_base_addr;
  logic             relu_en;
  logic [3:0]       out_shift;
  logic             ub_we;
  logic [AW-1:0]    ub_addr;
  logic [DB*MS-1:0] ub_data;
  logic             ub_ready;
  logic             busy;
  logic             done;
  logic             sat_err;
  logic             drop_err;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [DB*MS-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  model_acc [AD][MS];
  int  model_wr;
  int  model_used;
  int  row_v [MS];

  accumulator_writeback dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .acc_mode     (acc_mode),
    .flush        (flush),
    .wb_base_addr (wb_base_addr),
    .relu_en      (relu_en),
    .out_shift    (out_shift),
    .ub_we        (ub_we),
    .ub_addr      (ub_addr),
    .ub_data      (ub_data),
    .ub_ready     (ub_ready),
    .busy         (busy),
    .done         (done),
    .sat_err      (sat_err),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every accepted write must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && ub_we === 1'b1 && ub_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", ub_addr, ub_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (ub_addr !== mon_e.addr || ub_data !== mon_e.data) begin
          errors++;
          $display("FAIL wb_row got addr=%h data=%h exp addr=%h data=%h",
                   ub_addr, ub_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  function automatic int q_model(int v, bit relu, int sh);
    int t;
    t = v;
    if (relu && t < 0) t = 0;
    t = t >>> sh;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < AD; r++)
      for (int l = 0; l < MS; l++) model_acc[r][l] = 0;
    model_wr   = 0;
    model_used = 0;
  endtask

  task automatic fill(input int v);
    for (int l = 0; l < MS; l++) row_v[l] = v;
  endtask

  // One input cycle: optional row (from row_v) and optional flush.
  task automatic drive_cycle(input bit valid, input bit mode, input bit fl,
                             input logic [AW-1:0] base, input bit relu, input int sh);
    int  s;
    int  q;
    wr_t e;
    in_valid     = valid;
    acc_mode     = mode;
    flush        = fl;
    wb_base_addr = base;
    relu_en      = relu;
    out_shift    = sh[3:0];
    for (int l = 0; l < MS; l++) in_data[l*PS +: PS] = row_v[l][PS-1:0];
    if (valid) begin
      for (int l = 0; l < MS; l++) begin
        if (mode) begin
          s = model_acc[model_wr][l] + row_v[l];
          if (s > ACC_MAX) s = ACC_MAX;
          if (s < ACC_MIN) s = ACC_MIN;
        end else begin
          s = row_v[l];
        end
        model_acc[model_wr][l] = s;
      end
      model_wr = (model_wr + 1) % AD;
      if (model_used < AD) model_used++;
    end
    if (fl) begin
      for (int r = 0; r < model_used; r++) begin
        e.addr = base + AW'(r);
        for (int l = 0; l < MS; l++) begin
          q = q_model(model_acc[r][l], relu, sh);
          e.data[l*DB +: DB] = q[DB-1:0];
        end
        exp_q.push_back(e);
      end
      model_clear();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    @(negedge clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got done=%b exp 1 after %0d cycles", done, cyc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing got %0d pending exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ub_we, ub_addr, ub_data, busy, done, sat_err, drop_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h busy=%b done=%b sat=%b drop=%b exp all 0",
               ub_we, ub_addr, ub_data, busy, done, sat_err, drop_err);
    end
  endtask

  task automatic test_overwrite();
    int cyc;
    for (int i = 0; i < 2; i++) begin
      fill(5);
      drive_cycle(1, 0, 0, '0, 0, 0);
    end
    fill(5);
    drive_cycle(1, 0, 1, 10'h100, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ub_we !== 1'b1 || ub_addr !== AW'(10'h100 + i) || busy !== 1'b1) begin
        errors++;
        $display("FAIL overwrite_stream cycle %0d got we=%b addr=%h busy=%b exp 1 %h 1",
                 i, ub_we, ub_addr, busy, AW'(10'h100 + i));
      end
    end
    wait_done(cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL overwrite_done_latency got %0d exp 1", cyc);
    end
  endtask

  task automatic test_wrap_accumulate();
    int cyc;
    for (int i = 0; i < 8; i++) begin
      fill(100);
      drive_cycle(1, 1, 0, '0, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      fill(50);
      drive_cycle(1, 1, 0, '0, 0, 0);
    end
    drive_cycle(0, 0, 1, 10'h3FC, 0, 2);
    wait_done(cyc);
    checks++;
    if (sat_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sat_err got %b exp 0", sat_err);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [AW-1:0]    cap_addr;
    logic [DB*MS-1:0] cap_data;
    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < MS; l++) row_v[l] = r * 16 + l - 20;
      drive_cycle(1, 0, 0, '0, 0, 0);
    end
    ub_ready = 1'b1;
    drive_cycle(0, 0, 1, 10'h020, 1, 1);
    @(posedge clk);
    #1 ub_ready = 1'b0;
    @(negedge clk);
    cap_addr = ub_addr;
    cap_data = ub_data;
    checks++;
    if (ub_we !== 1'b1 || ub_addr !== 10'h021) begin
      errors++;
      $display("FAIL stall_present got we=%b addr=%h exp 1 021", ub_we, ub_addr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (ub_we !== 1'b1 || ub_addr !== cap_addr || ub_data !== cap_data) begin
      errors++;
      $display("FAIL stall_stable got we=%b addr=%h data=%h exp 1 %h %h",
               ub_we, ub_addr, ub_data, cap_addr, cap_data);
    end
    @(posedge clk);
    #1 ub_ready = 1'b1;
    wait_done(cyc);
  endtask

  task automatic test_empty_flush();
    drive_cycle(0, 0, 1, 10'h055, 0, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ub_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_flush_done got done=%b we=%b busy=%b exp 1 0 1", done, ub_we, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    int lanes [MS];
    lanes = '{-300, 127, 128, -128, -129, 40, 0, -1};
    for (int relu = 0; relu < 2; relu++) begin
      for (int l = 0; l < MS; l++) row_v[l] = lanes[l];
      drive_cycle(1, 0, 0, '0, 0, 0);
      drive_cycle(0, 0, 1, 10'h000, relu[0], 0);
      wait_done(cyc);
    end
    fill((1 << 19) - 1);
    for (int i = 0; i < 16 * AD; i++) drive_cycle(1, 1, 0, '0, 0, 0);
    checks++;
    if (sat_err !== 1'b0) begin
      errors++;
      $display("FAIL sat_early got %b exp 0", sat_err);
    end
    for (int i = 0; i < AD; i++) drive_cycle(1, 1, 0, '0, 0, 0);
    checks++;
    if (sat_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_set got %b exp 1", sat_err);
    end
    drive_cycle(0, 0, 1, 10'h180, 0, 0);
    wait_done(cyc);
    checks++;
    if (sat_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got %b exp 1", sat_err);
    end
  endtask

  task automatic test_drop();
    int cyc;
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_initial got %b exp 0", drop_err);
    end
    fill(9);
    drive_cycle(1, 0, 0, '0, 0, 0);
    fill(11);
    drive_cycle(1, 0, 0, '0, 0, 0);
    drive_cycle(0, 0, 1, 10'h200, 0, 0);
    // Row and a second flush arrive mid-drain: both must be ignored.
    in_valid = 1'b1;
    flush    = 1'b1;
    acc_mode = 1'b0;
    for (int l = 0; l < MS; l++) in_data[l*PS +: PS] = PS'(77);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    wait_done(cyc);
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_set got %b exp 1", drop_err);
    end
    drive_cycle(0, 0, 1, 10'h300, 0, 0);
    wait_done(cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL drop_not_stored got %0d cycles to done exp 1", cyc);
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    int bad;
    fill(3);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, '0, 0, 0);
    ub_ready = 1'b0;
    drive_cycle(0, 0, 1, 10'h0AA, 0, 0);
    @(negedge clk);
    checks++;
    if (ub_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain_active got we=%b busy=%b exp 1 1", ub_we, busy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({ub_we, ub_addr, ub_data, busy, done, sat_err, drop_err} !== '0) begin
      errors++;
      $display("FAIL mid_drain_reset got we=%b addr=%h data=%h busy=%b done=%b sat=%b drop=%b exp all 0",
               ub_we, ub_addr, ub_data, busy, done, sat_err, drop_err);
    end
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    ub_ready = 1'b1;
    bad      = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ub_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d active cycles exp 0", bad);
    end
    drive_cycle(0, 0, 1, 10'h010, 0, 0);
    wait_done(cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL post_reset_idle got %0d cycles to done exp 1", cyc);
    end
  endtask

  initial begin
    rstn         = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    acc_mode     = 1'b0;
    flush        = 1'b0;
    wb_base_addr = '0;
    relu_en      = 1'b0;
    out_shift    = '0;
    ub_ready     = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_overwrite();
    test_wrap_accumulate();
    test_backpressure();
    test_empty_flush();
    test_saturation();
    test_drop();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
